rom_loader: RTL and testbench
=============================

Name: rom_loader

Overview:
Boot-time writer for the instruction ROM's write port. It receives a byte stream over a valid/ready interface and unpacks a length header followed by little-endian 32-bit words. Each completed word is written into the ROM through its wen/w_addr_i/w_data_i port. While loading, the CPU core is held in reset; the hold is released when the load completes.

Parameters:
BASE_ADDR, 32'h0000_0000, byte address of the first word written (word-aligned).
MAX_WORDS, 4096, ROM capacity in words; matches the 4096-entry instruction ROM.

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-low
load_start_i  in  1  single-cycle pulse that starts a load; ignored unless in IDLE, DONE or ERROR
byte_valid_i  in  1  byte_data_i is valid
byte_data_i  in  8  incoming stream byte
byte_ready_o  out  1  loader accepts byte_data_i this cycle; a byte transfers when valid && ready
rom_wen_o  out  1  ROM write enable, one-cycle pulse per word
rom_waddr_o  out  32  ROM byte address; the ROM uses bits [13:2]
rom_wdata_o  out  32  ROM write data
cpu_hold_o  out  1  holds the CPU in reset while loading
load_done_o  out  1  level; load completed successfully
load_err_o  out  1  level; load aborted
word_cnt_o  out  13  number of words written so far

Behaviour:
- Reset (rst=0, async):
  - State IDLE.
  - byte_ready_o=0, rom_wen_o=0, rom_waddr_o=0, rom_wdata_o=0.
  - cpu_hold_o=1.
  - load_done_o=0, load_err_o=0, word_cnt_o=0.
  - Byte counter, word index and packer are cleared.
- States: IDLE, HDR, DATA, WRITE, CSUM (optional feature only), DONE, ERROR.
- IDLE:
  - cpu_hold_o=1, byte_ready_o=0.
  - load_start_i -> HDR; clears word_cnt_o, load_done_o and load_err_o.
- HDR:
  - byte_ready_o=1.
  - Accepts 4 bytes, little-endian (first byte = bits [7:0]), forming word count N.
  - After the 4th byte: N==0 -> DONE; N>MAX_WORDS -> ERROR; otherwise -> DATA.
- DATA:
  - byte_ready_o=1.
  - Packs 4 bytes little-endian into a word.
  - On acceptance of the 4th byte -> WRITE.
- WRITE (exactly one cycle):
  - byte_ready_o=0, rom_wen_o=1.
  - rom_waddr_o = BASE_ADDR + 4*word_cnt_o; rom_wdata_o = packed word.
  - word_cnt_o increments at the end of the cycle.
  - If word_cnt_o+1 == N -> DONE (or CSUM when the feature is enabled); otherwise -> DATA.
- Latency: rom_wen_o is asserted in the cycle immediately after the handshake of a word's 4th byte. Peak throughput is 4 bytes per 5 cycles.
- DONE:
  - cpu_hold_o=0, load_done_o=1, byte_ready_o=0.
  - load_start_i -> HDR (reload); cpu_hold_o reasserts in the same cycle.
- ERROR:
  - cpu_hold_o=1, load_err_o=1, byte_ready_o=0.
  - Only load_start_i or reset leaves ERROR.
- Outside WRITE: rom_wen_o=0; rom_waddr_o and rom_wdata_o hold their last values.
- byte_valid_i while byte_ready_o=0: no transfer; the byte is left pending upstream.
- load_start_i during HDR, DATA, WRITE or CSUM: ignored.
- Reset mid-load: abandon the load immediately. Words already written stay in the ROM; no partial word is written.
- word_cnt_o never exceeds MAX_WORDS. Address arithmetic is modulo 2^32.

Optional Feature:
ROM_LOADER_CSUM_EN
- Defined:
  - After the last WRITE, enter CSUM with byte_ready_o=1 and accept a 4-byte little-endian checksum.
  - The checksum is the sum of all data words modulo 2^32.
  - Match -> DONE; mismatch -> ERROR.
  - The running sum resets on load_start_i.
  - N==0 still goes through CSUM (expected checksum 0).
- Undefined: no trailer bytes; after the last WRITE go directly to DONE. No checksum logic is present.

Decomposition:
- Package rom_loader_pkg:
  - state enum encoding;
  - HDR_BYTES=4 and WORD_BYTES=4;
  - word-count width localparam ($clog2(MAX_WORDS)+1).
- Sub-module byte_packer:
  - 2-bit byte index plus a 32-bit little-endian shift/assemble register;
  - outputs word_o and last_byte_o;
  - reused for the header, the data words and the checksum.

Test Plan:
- Header 02 00 00 00, then bytes 13 00 00 00 93 00 10 00:
  - rom_wen_o pulses twice;
  - writes (addr 0x0, data 0x0000_0013) and (addr 0x4, data 0x0010_0093);
  - then load_done_o=1 and cpu_hold_o=0.
- Header 00 00 00 00 -> DONE with no rom_wen_o pulse and word_cnt_o=0.
- Header 01 10 00 00 (N=4097) -> ERROR: load_err_o=1, cpu_hold_o=1, no writes.
- Gaps in byte_valid_i between every byte of a 1-word load -> data is unchanged; byte_ready_o is low exactly during the WRITE cycle.
- rst asserted after 6 bytes of a 2-word load -> all outputs return to reset values at once. A following load_start_i plus a full frame completes normally.
- With ROM_LOADER_CSUM_EN, 1 word 0x0000_0013:
  - trailer 13 00 00 00 -> DONE;
  - trailer 14 00 00 00 -> ERROR.

Source files
------------

// File: rtl/rom_loader_pkg.sv
// -----------------------------------------------------------------------------
// rom_loader_pkg
// Shared definitions for the boot-time instruction ROM loader.
//   - state_e   : loader FSM state encoding
//   - HDR_BYTES : bytes in the little-endian word-count header
//   - WORD_BYTES: bytes per ROM data word (also the checksum trailer size)
//   - CNT_W     : width of the written-word counter ($clog2(MAX_WORDS)+1)
// Optional feature macro: ROM_LOADER_CSUM_EN (adds the checksum trailer state).
// -----------------------------------------------------------------------------
package rom_loader_pkg;

  localparam int HDR_BYTES     = 4;
  localparam int WORD_BYTES    = 4;
  localparam int MAX_WORDS_DEF = 4096;
  localparam int CNT_W         = $clog2(MAX_WORDS_DEF) + 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_DATA  = 3'd2,
    ST_WRITE = 3'd3,
    ST_CSUM  = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERROR = 3'd6
  } state_e;

endpackage

// File: rtl/rom_loader_byte_packer.sv
// -----------------------------------------------------------------------------
// rom_loader_byte_packer
// Assembles a little-endian 32-bit word from a byte stream. The header, each
// data word and the checksum trailer all pass through this one packer.
// Ports:
//   clk         in   system clock
//   rst         in   asynchronous active-low reset
//   clr_i       in   clear byte index and partial word (start of a new frame)
//   en_i        in   a byte is accepted this cycle
//   byte_i      in   incoming byte
//   word_o      out  assembled word, valid when last_byte_o && en_i
//   last_byte_o out  the byte currently offered completes a word
// Optional feature macro: none (ROM_LOADER_CSUM_EN is handled by the top).
// -----------------------------------------------------------------------------
module rom_loader_byte_packer
  import rom_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        last_byte_o
);

  // Header and data words share this packer, so size it for the larger one.
  localparam int NBYTES = (HDR_BYTES > WORD_BYTES) ? HDR_BYTES : WORD_BYTES;
  localparam int IDX_W  = $clog2(NBYTES);

  logic [IDX_W-1:0] idx_q;
  // Only the first three bytes need storage: the fourth is taken straight
  // from byte_i so the finished word is available in the handshake cycle.
  logic [23:0]      shift_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q   <= '0;
      shift_q <= '0;
    end else if (clr_i) begin
      idx_q   <= '0;
      shift_q <= '0;
    end else if (en_i) begin
      idx_q   <= idx_q + 1'b1;   // wraps to 0 after the last byte
      shift_q <= {byte_i, shift_q[23:8]};
    end
  end

  assign word_o      = {byte_i, shift_q};
  assign last_byte_o = (idx_q == IDX_W'(NBYTES - 1));

endmodule

// File: rtl/rom_loader.sv
// -----------------------------------------------------------------------------
// rom_loader
// Boot-time writer for the instruction ROM. Receives a byte stream (4-byte LE
// word count N, then N LE 32-bit words), writes each word into the ROM and
// holds the CPU in reset until the load completes.
// Parameters:
//   BASE_ADDR  byte address of the first word (word aligned)
//   MAX_WORDS  ROM capacity in words
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   load_start_i              start pulse (honoured in IDLE/DONE/ERROR only)
//   byte_valid_i/byte_data_i  byte stream in; byte_ready_o is the ready
//   rom_wen_o/rom_waddr_o/rom_wdata_o  ROM write port, one pulse per word
//   cpu_hold_o                CPU reset hold
//   load_done_o/load_err_o    completion / abort levels
//   word_cnt_o                words written in the current load
// Optional feature macro: ROM_LOADER_CSUM_EN -- when defined, a 4-byte LE
// checksum (sum of data words mod 2^32) follows the data and is verified.
// -----------------------------------------------------------------------------
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_start_i,
  input  logic             byte_valid_i,
  input  logic [7:0]       byte_data_i,
  output logic             byte_ready_o,
  output logic             rom_wen_o,
  output logic [31:0]      rom_waddr_o,
  output logic [31:0]      rom_wdata_o,
  output logic             cpu_hold_o,
  output logic             load_done_o,
  output logic             load_err_o,
  output logic [CNT_W-1:0] word_cnt_o
);

  localparam logic [31:0] MAX_WORDS_32 = 32'(MAX_WORDS);

  state_e           state_q;
  logic             ready_q;
  logic             wen_q;
  logic [31:0]      waddr_q;
  logic [31:0]      wdata_q;
  logic             hold_q;
  logic             done_q;
  logic             err_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      nwords_q;
`ifdef ROM_LOADER_CSUM_EN
  logic [31:0]      sum_q;
`endif

  logic             xfer;
  logic             start_ok;
  logic [31:0]      pk_word;
  logic             pk_last;
  logic [CNT_W-1:0] cnt_d;
  logic [31:0]      waddr_d;

  assign xfer     = byte_valid_i & ready_q;
  assign start_ok = load_start_i &
                    ((state_q == ST_IDLE) | (state_q == ST_DONE) | (state_q == ST_ERROR));
  assign cnt_d    = cnt_q + 1'b1;
  assign waddr_d  = BASE_ADDR + (32'(cnt_q) << 2);   // modulo 2^32

  rom_loader_byte_packer u_packer (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (start_ok),
    .en_i        (xfer),
    .byte_i      (byte_data_i),
    .word_o      (pk_word),
    .last_byte_o (pk_last)
  );

  // All outputs are registered and updated together with the state, so each
  // output already reflects the state it belongs to.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      ready_q  <= 1'b0;
      wen_q    <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      hold_q   <= 1'b1;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      nwords_q <= '0;
`ifdef ROM_LOADER_CSUM_EN
      sum_q    <= '0;
`endif
    end else begin
      wen_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (load_start_i) begin
            state_q <= ST_HDR;
            ready_q <= 1'b1;
            hold_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
`ifdef ROM_LOADER_CSUM_EN
            sum_q   <= '0;
`endif
          end
        end

        ST_HDR: begin
          if (xfer && pk_last) begin
            nwords_q <= pk_word;
            if (pk_word == '0) begin
`ifdef ROM_LOADER_CSUM_EN
              state_q <= ST_CSUM;        // empty image still carries a checksum
`else
              state_q <= ST_DONE;
              ready_q <= 1'b0;
              hold_q  <= 1'b0;
              done_q  <= 1'b1;
`endif
            end else if (pk_word > MAX_WORDS_32) begin
              state_q <= ST_ERROR;
              ready_q <= 1'b0;
              err_q   <= 1'b1;
            end else begin
              state_q <= ST_DATA;
            end
          end
        end

        ST_DATA: begin
          if (xfer && pk_last) begin
            state_q <= ST_WRITE;
            ready_q <= 1'b0;
            wen_q   <= 1'b1;
            waddr_q <= waddr_d;
            wdata_q <= pk_word;
          end
        end

        ST_WRITE: begin
          cnt_q <= cnt_d;
`ifdef ROM_LOADER_CSUM_EN
          sum_q <= sum_q + wdata_q;
`endif
          if (32'(cnt_d) == nwords_q) begin
`ifdef ROM_LOADER_CSUM_EN
            state_q <= ST_CSUM;
            ready_q <= 1'b1;
`else
            state_q <= ST_DONE;
            hold_q  <= 1'b0;
            done_q  <= 1'b1;
`endif
          end else begin
            state_q <= ST_DATA;
            ready_q <= 1'b1;
          end
        end

`ifdef ROM_LOADER_CSUM_EN
        ST_CSUM: begin
          if (xfer && pk_last) begin
            ready_q <= 1'b0;
            if (pk_word == sum_q) begin
              state_q <= ST_DONE;
              hold_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_ERROR;
              err_q   <= 1'b1;
            end
          end
        end
`endif

        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign byte_ready_o = ready_q;
  assign rom_wen_o    = wen_q;
  assign rom_waddr_o  = waddr_q;
  assign rom_wdata_o  = wdata_q;
  assign cpu_hold_o   = hold_q;
  assign load_done_o  = done_q;
  assign load_err_o   = err_q;
  assign word_cnt_o   = cnt_q;

endmodule

// File: tb/tb_rom_loader.sv
// -----------------------------------------------------------------------------
// tb_rom_loader
// Self-checking bench for rom_loader. Frames are built from a word list; the
// expected ROM writes, final status and word count follow directly from the
// frame contents (N, the words, and the checksum when ROM_LOADER_CSUM_EN is
// defined).
// -----------------------------------------------------------------------------
module tb_rom_loader;

  localparam int          MAX_WORDS = 4096;
  localparam logic [31:0] BASE_ADDR = 32'h0000_0000;
`ifdef ROM_LOADER_CSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load_start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready_o;
  logic        rom_wen_o;
  logic [31:0] rom_waddr_o;
  logic [31:0] rom_wdata_o;
  logic        cpu_hold_o;
  logic        load_done_o;
  logic        load_err_o;
  logic [12:0] word_cnt_o;

  int total = 0;
  int bad   = 0;

  logic [31:0] words_q[$];   // data words of the frame being sent
  logic [63:0] got_q[$];     // {addr, data} of observed ROM writes

  always #5 clk = ~clk;

  rom_loader #(.BASE_ADDR(BASE_ADDR), .MAX_WORDS(MAX_WORDS)) dut (
    .clk          (clk),
    .rst          (rst),
    .load_start_i (load_start),
    .byte_valid_i (byte_valid),
    .byte_data_i  (byte_data),
    .byte_ready_o (byte_ready_o),
    .rom_wen_o    (rom_wen_o),
    .rom_waddr_o  (rom_waddr_o),
    .rom_wdata_o  (rom_wdata_o),
    .cpu_hold_o   (cpu_hold_o),
    .load_done_o  (load_done_o),
    .load_err_o   (load_err_o),
    .word_cnt_o   (word_cnt_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Record every ROM write; the stream must be stalled while a word is written.
  always @(negedge clk) begin
    if (rst && rom_wen_o) begin
      got_q.push_back({rom_waddr_o, rom_wdata_o});
      check("ready_low_in_write", {31'd0, byte_ready_o}, 32'd0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_start();
    @(negedge clk);
    byte_valid = 1'b0;
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  // Offer one byte after 'gap' idle cycles and hold it until it is accepted.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    repeat (gap) begin
      @(negedge clk);
      byte_valid = 1'b0;
    end
    @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (byte_ready_o) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) @(posedge clk);
    else begin
      byte_valid = 1'b0;
      check("ready_timeout", 32'd0, 32'd1);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int gapmax);
    logic [31:0] v;
    v = w;
    for (int b = 0; b < 4; b++) send_byte(v[8*b +: 8], $urandom_range(0, gapmax));
  endtask

  // Start a load with header n and the words in words_q, then check the
  // complete set of writes and the final status against the frame contents.
  task automatic run_frame(input logic [31:0] n, input int gapmax, input bit poke, input bit bad_sum);
    bit          accept;
    bit          exp_err;
    logic [31:0] sum;
    logic [31:0] exp_n;
    int          wcnt;
    logic [63:0] ent;

    got_q.delete();
    do_start();
    check("hdr_ready", {31'd0, byte_ready_o}, 32'd1);
    check("hdr_hold", {31'd0, cpu_hold_o}, 32'd1);
    check("hdr_flags", {30'd0, load_done_o, load_err_o}, 32'd0);
    check("hdr_cnt", {19'd0, word_cnt_o}, 32'd0);

    accept = (n <= 32'(MAX_WORDS));
    send_word(n, gapmax);
    sum = 32'd0;
    if (accept) begin
      for (int w = 0; w < int'(n); w++) begin
        for (int b = 0; b < 4; b++) begin
          ent[31:0] = words_q[w];
          send_byte(ent[8*b +: 8], $urandom_range(0, gapmax));
          if (poke && w == 0 && b == 0) begin
            // A start pulse mid-load must have no effect.
            @(negedge clk);
            byte_valid = 1'b0;
            load_start = 1'b1;
            @(negedge clk);
            load_start = 1'b0;
          end
        end
        sum = sum + words_q[w];
      end
      if (CSUM) send_word(sum + {31'd0, bad_sum}, gapmax);
    end
    @(negedge clk);
    byte_valid = 1'b0;

    for (int i = 0; i < 20 && !(load_done_o || load_err_o); i++) @(negedge clk);

    exp_err = !accept || (CSUM && bad_sum);
    exp_n   = accept ? n : 32'd0;
    wcnt    = int'(exp_n);
    check("done", {31'd0, load_done_o}, {31'd0, !exp_err});
    check("err", {31'd0, load_err_o}, {31'd0, exp_err});
    check("hold", {31'd0, cpu_hold_o}, {31'd0, exp_err});
    check("ready_end", {31'd0, byte_ready_o}, 32'd0);
    check("word_cnt", {19'd0, word_cnt_o}, exp_n);
    check("num_writes", got_q.size(), exp_n);
    for (int i = 0; i < wcnt && i < got_q.size(); i++) begin
      ent = got_q[i];
      check($sformatf("waddr[%0d]", i), ent[63:32], BASE_ADDR + 32'(i) * 32'd4);
      check($sformatf("wdata[%0d]", i), ent[31:0], words_q[i]);
    end
    $display("frame n=%0d gapmax=%0d poke=%0d bad_sum=%0d -> writes=%0d done=%0d err=%0d",
             n, gapmax, poke, bad_sum, got_q.size(), load_done_o, load_err_o);
  endtask

  initial begin
    logic [31:0] n;
    int          kind;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, byte_ready_o}, 32'd0);
    check("rst_wen", {31'd0, rom_wen_o}, 32'd0);
    check("rst_waddr", rom_waddr_o, 32'd0);
    check("rst_wdata", rom_wdata_o, 32'd0);
    check("rst_hold", {31'd0, cpu_hold_o}, 32'd1);
    check("rst_flags", {30'd0, load_done_o, load_err_o}, 32'd0);
    check("rst_cnt", {19'd0, word_cnt_o}, 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_ready", {31'd0, byte_ready_o}, 32'd0);
    check("idle_hold", {31'd0, cpu_hold_o}, 32'd1);

    // Two-word image
    words_q = '{32'h0000_0013, 32'h0010_0093};
    run_frame(32'd2, 0, 1'b0, 1'b0);

    // A byte offered while DONE must not be taken
    @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = 8'hA5;
    repeat (4) begin
      @(negedge clk);
      check("done_no_ready", {31'd0, byte_ready_o}, 32'd0);
    end
    check("done_cnt_kept", {19'd0, word_cnt_o}, 32'd2);
    byte_valid = 1'b0;

    // Empty image
    words_q.delete();
    run_frame(32'd0, 0, 1'b0, 1'b0);

    // Oversize image (N = 4097)
    run_frame(32'h0000_1001, 0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("err_sticky", {31'd0, load_err_o}, 32'd1);

    // One word with gaps between every byte and a stray start pulse
    words_q = '{32'hDEAD_BEEF};
    run_frame(32'd1, 3, 1'b1, 1'b0);

    // Reset after 6 bytes of a 2-word load
    words_q = '{32'h1122_3344, 32'h5566_7788};
    do_start();
    send_word(32'd2, 0);
    send_byte(8'h44, 0);
    send_byte(8'h33, 0);
    @(negedge clk);
    byte_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("mid_rst_ready", {31'd0, byte_ready_o}, 32'd0);
    check("mid_rst_wen", {31'd0, rom_wen_o}, 32'd0);
    check("mid_rst_waddr", rom_waddr_o, 32'd0);
    check("mid_rst_wdata", rom_wdata_o, 32'd0);
    check("mid_rst_hold", {31'd0, cpu_hold_o}, 32'd1);
    check("mid_rst_flags", {30'd0, load_done_o, load_err_o}, 32'd0);
    check("mid_rst_cnt", {19'd0, word_cnt_o}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    run_frame(32'd2, 1, 1'b0, 1'b0);

`ifdef ROM_LOADER_CSUM_EN
    words_q = '{32'h0000_0013};
    run_frame(32'd1, 0, 1'b0, 1'b0);
    run_frame(32'd1, 0, 1'b0, 1'b1);
`endif

    // Randomised frames
    for (int it = 0; it < 12; it++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0)      n = 32'd0;
      else if (kind == 1) n = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF
                                                          : 32'd4097 + 32'($urandom_range(0, 50));
      else                n = 32'($urandom_range(1, 6));
      words_q.delete();
      if (n <= 32'(MAX_WORDS))
        for (int w = 0; w < int'(n); w++) words_q.push_back($urandom);
      run_frame(n, $urandom_range(0, 2), ($urandom_range(0, 3) == 0) && (n != 0),
                CSUM && ($urandom_range(0, 3) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
